// File: rtl/wordline_ring_buffer_pkg.sv
// wordline_ring_buffer_pkg: shared sizing constants, mode encoding and pointer-width helper
package wordline_ring_buffer_pkg;
  localparam int BSIZE = 10;
  localparam int BSIZE_LOG2 = $clog2(BSIZE);
  typedef enum logic {FIFO, OVERWRITE} buf_mode_t;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/wordline_ptr_inc.sv
// wordline_ptr_inc: modulo-DEPTH pointer increment without power-of-two masking
module wordline_ptr_inc import wordline_ring_buffer_pkg::*; #(
  parameter int DEPTH = BSIZE,
  parameter int PW = ptr_w(DEPTH)
) (
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] nxt
);
  // wrap from the last slot back to zero
  always_comb nxt = ptr == PW'(DEPTH - 1) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/wordline_ring_buffer.sv
// wordline_ring_buffer: first-word fall-through ring buffer with optional overwrite-oldest mode
module wordline_ring_buffer import wordline_ring_buffer_pkg::*; #(
  parameter int DEPTH = BSIZE,
  parameter int WIDTH = 32,
  parameter int OVERWRITE = 0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam buf_mode_t MODE = OVERWRITE != 0 ? buf_mode_t'(1'b1) : FIFO;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail, head_nxt, tail_nxt;
  logic push, pop, ovf, full;
  wordline_ptr_inc #(.DEPTH(DEPTH), .PW(PW)) u_head (.ptr(head), .nxt(head_nxt));
  wordline_ptr_inc #(.DEPTH(DEPTH), .PW(PW)) u_tail (.ptr(tail), .nxt(tail_nxt));
  // handshakes and status derived from registered state only
  always_comb begin
    full = count == CNT_W'(DEPTH);
    push_ready = MODE == FIFO ? !full : 1'b1;
    pop_valid = count != '0;
    pop_data = mem[head];
    push = push_valid && push_ready;
    pop = pop_valid && pop_ready;
    ovf = push && !pop && full;
  end
  // storage is written only by accepted pushes; flush and reset leave it intact
  always_ff @(posedge clk)
    if (!rst && !flush && push) mem[tail] <= push_data;
  // pointers, occupancy and overflow pulse; an overwrite drops the oldest entry by advancing head
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail_nxt;
      if (pop || ovf) head <= head_nxt;
      count <= count + CNT_W'(push && !ovf) - CNT_W'(pop);
      overflow <= ovf;
    end
  end
endmodule

// File: tb/tb_wordline_ring_buffer.sv
// tb_wordline_ring_buffer: scenario and randomized checks of FIFO and overwrite instances against a queue model
module tb_wordline_ring_buffer;
  localparam int D = 10;
  logic clk = 0, rst = 1, flush = 0, push_valid = 0, pop_ready = 0;
  logic [31:0] push_data = 0;
  logic f_prdy, f_vld, f_ovf, o_prdy, o_vld, o_ovf;
  logic [31:0] f_data, o_data;
  logic [3:0] f_cnt, o_cnt;
  logic [31:0] fq[$], oq[$];
  bit exp_ovf;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  wordline_ring_buffer #(.DEPTH(D), .WIDTH(32), .OVERWRITE(0)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid), .push_ready(f_prdy),
    .push_data(push_data), .pop_valid(f_vld), .pop_ready(pop_ready), .pop_data(f_data),
    .count(f_cnt), .overflow(f_ovf));

  wordline_ring_buffer #(.DEPTH(D), .WIDTH(32), .OVERWRITE(1)) u_ovw (
    .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid), .push_ready(o_prdy),
    .push_data(push_data), .pop_valid(o_vld), .pop_ready(pop_ready), .pop_data(o_data),
    .count(o_cnt), .overflow(o_ovf));

  // one clock with the given inputs; the queue models apply the buffer rules afterwards
  task automatic cycle(input bit r, input bit fl, input bit pv, input logic [31:0] d, input bit pr);
    bit fpush, fpop, opop, ovf;
    rst = r; flush = fl; push_valid = pv; push_data = d; pop_ready = pr;
    fpush = pv && fq.size() < D;
    fpop = pr && fq.size() != 0;
    opop = pr && oq.size() != 0;
    ovf = pv && !opop && oq.size() == D;
    @(posedge clk); #1;
    if (r || fl) begin
      fq.delete(); oq.delete(); exp_ovf = 0;
    end else begin
      if (fpop) void'(fq.pop_front());
      if (fpush) fq.push_back(d);
      if (opop) void'(oq.pop_front());
      if (ovf) void'(oq.pop_front());
      if (pv) oq.push_back(d);
      exp_ovf = ovf;
    end
    rst = 0; flush = 0; push_valid = 0; pop_ready = 0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 32'h55, 1);
    n_checks++; if (f_cnt !== 0 || o_cnt !== 0) begin n_fail++; $display("FAIL reset_count: got %0d/%0d want 0", f_cnt, o_cnt); end
    n_checks++; if (f_vld !== 0 || o_vld !== 0) begin n_fail++; $display("FAIL reset_pop_valid: got %b/%b want 0", f_vld, o_vld); end
    n_checks++; if (f_prdy !== 1 || o_prdy !== 1) begin n_fail++; $display("FAIL reset_push_ready: got %b/%b want 1", f_prdy, o_prdy); end
    n_checks++; if (f_ovf !== 0 || o_ovf !== 0) begin n_fail++; $display("FAIL reset_overflow: got %b/%b want 0", f_ovf, o_ovf); end
  endtask

  task automatic test_fifo_fill();
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (f_prdy !== (i < D)) begin n_fail++; $display("FAIL fill_push_ready[%0d]: got %b want %b", i, f_prdy, i < D); end
      cycle(0, 0, 1, i, 0);
    end
    n_checks++; if (f_cnt !== 4'(D)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", f_cnt, D); end
    for (int i = 0; i < D; i++) begin
      n_checks++; if (f_vld !== 1 || f_data !== i) begin n_fail++; $display("FAIL fill_pop[%0d]: got v=%b d=%0d want v=1 d=%0d", i, f_vld, f_data, i); end
      cycle(0, 0, 0, 0, 1);
    end
    n_checks++; if (f_vld !== 0) begin n_fail++; $display("FAIL fill_drained: got pop_valid=%b want 0", f_vld); end
  endtask

  task automatic test_full_push_pop();
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < D; i++) cycle(0, 0, 1, i, 0);
    n_checks++; if (f_prdy !== 0) begin n_fail++; $display("FAIL full_push_ready: got %b want 0", f_prdy); end
    cycle(0, 0, 1, 32'hA, 1);
    n_checks++; if (f_cnt !== 4'(D - 1) || f_prdy !== 1) begin n_fail++; $display("FAIL full_after_pop: got cnt=%0d rdy=%b want cnt=%0d rdy=1", f_cnt, f_prdy, D - 1); end
    for (int i = 1; i < D; i++) begin
      n_checks++; if (f_data !== i) begin n_fail++; $display("FAIL full_drain[%0d]: got %0d want %0d", i, f_data, i); end
      cycle(0, 0, 0, 0, 1);
    end
    n_checks++; if (f_vld !== 0) begin n_fail++; $display("FAIL full_a_dropped: got pop_valid=%b want 0", f_vld); end
  endtask

  task automatic test_overwrite();
    int pulses = 0;
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      n_checks++; if (o_prdy !== 1) begin n_fail++; $display("FAIL ovw_push_ready[%0d]: got %b want 1", i, o_prdy); end
      cycle(0, 0, 1, i, 0);
      pulses += int'(o_ovf);
    end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL ovw_pulses: got %0d want 3", pulses); end
    n_checks++; if (o_cnt !== 4'(D)) begin n_fail++; $display("FAIL ovw_count: got %0d want %0d", o_cnt, D); end
    for (int i = 0; i < D; i++) begin
      n_checks++; if (o_data !== i + 3) begin n_fail++; $display("FAIL ovw_pop[%0d]: got %0d want %0d", i, o_data, i + 3); end
      cycle(0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_wrap();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 100, 0);
    for (int i = 0; i < 25; i++) begin
      n_checks++; if (f_data !== 100 + i || o_data !== 100 + i) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0d/%0d want %0d", i, f_data, o_data, 100 + i); end
      cycle(0, 0, 1, 101 + i, 1);
      n_checks++; if (f_cnt !== 1 || o_cnt !== 1 || o_ovf !== 0) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d/%0d ovf=%b want 1/1 ovf=0", i, f_cnt, o_cnt, o_ovf); end
    end
  endtask

  task automatic test_flush();
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 200 + i, 0);
    n_checks++; if (f_cnt !== 6) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 6", f_cnt); end
    cycle(0, 1, 1, 999, 1);
    n_checks++; if (f_cnt !== 0 || f_vld !== 0 || o_cnt !== 0 || o_vld !== 0) begin n_fail++; $display("FAIL flush_state: got %0d/%b %0d/%b want 0/0", f_cnt, f_vld, o_cnt, o_vld); end
    cycle(0, 0, 0, 0, 0);
    n_checks++; if (f_vld !== 0 || f_cnt !== 0 || o_ovf !== 0) begin n_fail++; $display("FAIL flush_word_lost: got v=%b cnt=%0d ovf=%b want 0", f_vld, f_cnt, o_ovf); end
  endtask

  task automatic test_rst_mid();
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 300 + i, 0);
    cycle(1, 0, 1, 777, 0);
    n_checks++; if (f_cnt !== 0 || f_prdy !== 1 || f_vld !== 0 || f_ovf !== 0) begin n_fail++; $display("FAIL rst_mid: got cnt=%0d rdy=%b v=%b ovf=%b want 0/1/0/0", f_cnt, f_prdy, f_vld, f_ovf); end
    for (int i = 0; i < D; i++) cycle(0, 0, 1, i, 0);
    cycle(1, 0, 1, 5, 0);
    n_checks++; if (o_cnt !== 0 || o_ovf !== 0 || o_vld !== 0) begin n_fail++; $display("FAIL rst_full_ovw: got cnt=%0d ovf=%b v=%b want 0/0/0", o_cnt, o_ovf, o_vld); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      cycle($urandom_range(255) == 0, $urandom_range(63) == 0, $urandom_range(2) != 0, $urandom, $urandom_range(1) == 1);
      n_checks++;
      if ({f_cnt, f_vld, f_prdy, f_ovf} !== {4'(fq.size()), fq.size() != 0, fq.size() != D, 1'b0})
        begin n_fail++; $display("FAIL rand_fifo_status[%0d]: got cnt=%0d v=%b r=%b o=%b want cnt=%0d", n, f_cnt, f_vld, f_prdy, f_ovf, fq.size()); end
      n_checks++;
      if ({o_cnt, o_vld, o_prdy, o_ovf} !== {4'(oq.size()), oq.size() != 0, 1'b1, exp_ovf})
        begin n_fail++; $display("FAIL rand_ovw_status[%0d]: got cnt=%0d v=%b r=%b o=%b want cnt=%0d o=%b", n, o_cnt, o_vld, o_prdy, o_ovf, oq.size(), exp_ovf); end
      if (fq.size() != 0) begin
        n_checks++; if (f_data !== fq[0]) begin n_fail++; $display("FAIL rand_fifo_data[%0d]: got %h want %h", n, f_data, fq[0]); end
      end
      if (oq.size() != 0) begin
        n_checks++; if (o_data !== oq[0]) begin n_fail++; $display("FAIL rand_ovw_data[%0d]: got %h want %h", n, o_data, oq[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fifo_fill();
    test_full_push_pop();
    test_overwrite();
    test_wrap();
    test_flush();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wordline_ring_buffer.md
WORDLINE_RING_BUFFER -- requirements
Module: wordline_ring_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default BSIZE (10), meaning the number of stored wordlines; any value 2..1024, power of two not required.
REQ-002 SHALL have parameter WIDTH, default 32, meaning the wordline data width in bits.
REQ-003 SHALL have parameter OVERWRITE, default 0, meaning 0 = lossless FIFO mode and 1 = circular overwrite-oldest mode.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-006 SHALL have port flush, input, 1 bit: discards all stored entries.
REQ-007 SHALL have port push_valid, input, 1 bit, and port push_ready, output, 1 bit: the write handshake.
REQ-008 SHALL have port push_data, input, WIDTH bits: the write data.
REQ-009 SHALL have port pop_valid, output, 1 bit, and port pop_ready, input, 1 bit: the read handshake.
REQ-010 SHALL have port pop_data, output, WIDTH bits: the oldest stored entry.
REQ-011 SHALL have port count, output, CNT_W bits: the occupancy, where CNT_W = $clog2(DEPTH+1).
REQ-012 SHALL have port overflow, output, 1 bit: a one-cycle pulse when an entry is overwritten.

Function
REQ-013 SHALL transfer a push when push_valid && push_ready, and a pop when pop_valid && pop_ready, both sampled at the clock edge.
REQ-014 SHALL hold its state in head/tail pointers of width max(1,$clog2(DEPTH)), plus a registered count.
REQ-015 SHALL wrap each pointer from DEPTH-1 to 0; no power-of-two masking is permitted.
REQ-016 SHALL drive pop_valid = (count != 0) and pop_data = mem[head] (first-word fall-through).
REQ-017 SHALL make pushed data visible as pop_valid one cycle after the push into an empty buffer; there is no combinational push-to-pop bypass.
REQ-018 SHALL, when OVERWRITE=0, drive push_ready = (count != DEPTH), registered-derived, with no dependence on pop_ready.
REQ-019 SHALL, when OVERWRITE=1, hold push_ready at constant 1.
REQ-020 SHALL, on a simultaneous push and pop, write at tail, advance both pointers and leave count unchanged; this is legal at count = 1 and at count = DEPTH.
REQ-021 SHALL, when OVERWRITE=1 and a push occurs at count = DEPTH with no pop, write at tail, advance both tail and head, leave count at DEPTH, and pulse overflow on the following cycle.
REQ-022 SHALL keep count within 0..DEPTH: a pop at empty is impossible (pop_valid=0), and a push at full is blocked in FIFO mode.
REQ-023 SHALL, when flush=1, set head, tail and count to 0 on the next cycle; flush overrides any same-cycle push or pop, and no overflow pulse is produced.
REQ-024 SHALL leave mem contents unchanged on flush and reset; they are not cleared.

Reset
REQ-025 SHALL, when rst=1 at an edge, force head=0, tail=0, count=0 and overflow=0, giving pop_valid=0 and push_ready=1, regardless of any operation in progress.
REQ-026 SHALL give rst priority over flush, push and pop.

Structure
REQ-027 SHALL take BSIZE and BSIZE_LOG2 from the shared package as the DEPTH default and pointer-width reference, and SHALL add a package enum buf_mode_t {FIFO, OVERWRITE} for the mode encoding.
REQ-028 SHALL use one sub-module, wordline_ptr_inc, that performs a modulo-DEPTH pointer increment and is instantiated for both head and tail.
REQ-029 SHALL implement storage as an inferred register array without reset.

Verification
REQ-030 SHALL be covered by: DEPTH=10, FIFO: push 0..11 with pop_ready=0 -> push_ready drops after 10 accepted, count=10, and pops return 0..9 in order.
REQ-031 SHALL be covered by: DEPTH=10, FIFO, full: push A with pop at the same cycle -> push_ready=0, so A is not accepted; next cycle push_ready=1 and count=9.
REQ-032 SHALL be covered by: DEPTH=10, OVERWRITE=1: push 0..12 -> overflow pulses 3 times, count=10, and pops return 3..12.
REQ-033 SHALL be covered by: DEPTH=10: 25 continuous push+pop cycles at count=1 -> pointers wrap past 9 to 0, data remains in order, count stays 1.
REQ-034 SHALL be covered by: count=6, assert flush together with push_valid -> next cycle count=0, pop_valid=0, and the pushed word is lost.
REQ-035 SHALL be covered by: rst pulsed for one cycle at count=7 during a push -> next cycle count=0, push_ready=1, pop_valid=0, overflow=0.
